// File: rtl/alu4_pkg.sv
// Shared opcode encodings and datapath widths for the 4-bit ALU.
package alu4_pkg;

    localparam int unsigned OPERAND_W = 4;
    localparam int unsigned RESULT_W  = 5;
    localparam int unsigned OPCODE_W  = 2;

    localparam logic [OPCODE_W-1:0] OP_ADD = 2'd0;
    localparam logic [OPCODE_W-1:0] OP_SUB = 2'd1;
    localparam logic [OPCODE_W-1:0] OP_MUL = 2'd2;
    localparam logic [OPCODE_W-1:0] OP_AND = 2'd3;

endpackage

// File: rtl/alu4_comb.sv
// Combinational opcode decode and datapath: next result and next overflow flag.
module alu4_comb
    import alu4_pkg::*;
(
    input  logic [OPERAND_W-1:0] a,
    input  logic [OPERAND_W-1:0] b,
    input  logic [OPCODE_W-1:0]  op,
    output logic [RESULT_W-1:0]  res,
    output logic                 ovf
);

    logic [2*OPERAND_W-1:0] prod;

    assign prod = {4'b0000, a} * {4'b0000, b};

    always_comb begin
        res = '0;
        ovf = 1'b0;
        unique case (op)
            OP_ADD: res = {1'b0, a} + {1'b0, b};
            // 5-bit two's complement covers the full -15..+15 range
            OP_SUB: res = {1'b0, a} - {1'b0, b};
            OP_MUL: begin
                res = prod[RESULT_W-1:0];
                ovf = |prod[2*OPERAND_W-1:RESULT_W];
            end
            OP_AND: res = {1'b0, a & b};
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/alu4.sv
// Single-cycle ALU execution stage: registered result, zero, overflow and valid.
module alu4
    import alu4_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [OPERAND_W-1:0] in_1,
    input  logic [OPERAND_W-1:0] in_2,
    input  logic [OPCODE_W-1:0]  control,
    input  logic                 in_valid,
    output logic [RESULT_W-1:0]  out,
    output logic                 out_valid,
    output logic                 zero,
    output logic                 ovf
);

    logic [RESULT_W-1:0] res_d;
    logic                ovf_d;

    alu4_comb u_comb (
        .a   (in_1),
        .b   (in_2),
        .op  (control),
        .res (res_d),
        .ovf (ovf_d)
    );

    // Result flags hold when idle; only the valid strobe drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out       <= '0;
            out_valid <= 1'b0;
            zero      <= 1'b1;
            ovf       <= 1'b0;
        end else if (in_valid) begin
            out       <= res_d;
            out_valid <= 1'b1;
            zero      <= (res_d == '0);
            ovf       <= ovf_d;
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu4.sv
// Scoreboard bench for alu4: directed vectors with hand-computed results.
module tb_alu4;

    logic       clk;
    logic       rst;
    logic [3:0] in_1;
    logic [3:0] in_2;
    logic [1:0] control;
    logic       in_valid;
    logic [4:0] out;
    logic       out_valid;
    logic       zero;
    logic       ovf;

    alu4 dut (
        .clk       (clk),
        .rst       (rst),
        .in_1      (in_1),
        .in_2      (in_2),
        .control   (control),
        .in_valid  (in_valid),
        .out       (out),
        .out_valid (out_valid),
        .zero      (zero),
        .ovf       (ovf)
    );

    typedef struct {
        logic [4:0] out;
        logic       zero;
        logic       ovf;
        int         cap;
    } exp_t;

    exp_t sb[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   cyc = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        else
            n_pass++;
    endtask

    // Drives one operation for the next rising edge and records its expected result.
    task automatic issue(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic [4:0] e_out, input logic e_zero, input logic e_ovf);
        exp_t e;
        control  = op;
        in_1     = a;
        in_2     = b;
        in_valid = 1'b1;
        e.out  = e_out;
        e.zero = e_zero;
        e.ovf  = e_ovf;
        e.cap  = cyc + 1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: pops an expectation whenever the DUT presents a result.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("out", 32'(out), 32'(e.out));
                    chk("zero", 32'(zero), 32'(e.zero));
                    chk("ovf", 32'(ovf), 32'(e.ovf));
                    chk("latency", 32'(cyc), 32'(e.cap));
                end
            end else if (sb.size() > 0 && sb[0].cap <= cyc) begin
                chk("missing_valid", 32'd0, 32'd1);
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        in_1 = '0;
        in_2 = '0;
        control = '0;
        in_valid = 1'b0;
        #1;
        chk("rst_out", 32'(out), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_zero", 32'(zero), 32'd1);
        chk("rst_ovf", 32'(ovf), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // ADD / SUB with idle gaps
        issue(2'd0, 4'd5, 4'd12, 5'd17, 1'b0, 1'b0);
        idle(1);
        issue(2'd1, 4'd3, 4'd8, 5'b11011, 1'b0, 1'b0);
        idle(1);
        issue(2'd1, 4'd9, 4'd5, 5'd4, 1'b0, 1'b0);
        issue(2'd1, 4'd7, 4'd7, 5'd0, 1'b1, 1'b0);
        idle(1);
        // MUL
        issue(2'd2, 4'd3, 4'd2, 5'd6, 1'b0, 1'b0);
        issue(2'd2, 4'd3, 4'd10, 5'd30, 1'b0, 1'b0);
        issue(2'd2, 4'd15, 4'd15, 5'd1, 1'b0, 1'b1);
        // AND
        issue(2'd3, 4'd14, 4'd8, 5'd8, 1'b0, 1'b0);
        issue(2'd3, 4'd5, 4'd10, 5'd0, 1'b1, 1'b0);
        idle(1);

        // Hold: operands change while in_valid is low
        issue(2'd0, 4'd5, 4'd12, 5'd17, 1'b0, 1'b0);
        in_1 = 4'd2;
        in_2 = 4'd3;
        control = 2'd2;
        @(posedge clk);
        @(negedge clk);
        chk("hold_out", 32'(out), 32'd17);
        chk("hold_valid", 32'(out_valid), 32'd0);
        chk("hold_zero", 32'(zero), 32'd0);
        @(posedge clk);
        #1;

        // Back-to-back ADD, SUB, MUL
        issue(2'd0, 4'd15, 4'd15, 5'd30, 1'b0, 1'b0);
        issue(2'd1, 4'd0, 4'd15, 5'b10001, 1'b0, 1'b0);
        issue(2'd2, 4'd4, 4'd8, 5'd0, 1'b1, 1'b1);
        idle(1);

        // Asynchronous reset mid-cycle after a nonzero, overflowing result
        issue(2'd2, 4'd15, 4'd15, 5'd1, 1'b0, 1'b1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out", 32'(out), 32'd0);
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_zero", 32'(zero), 32'd1);
        chk("arst_ovf", 32'(ovf), 32'd0);
        // Operation presented while reset is held is discarded
        control = 2'd0;
        in_1 = 4'd6;
        in_2 = 4'd7;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_discard_out", 32'(out), 32'd0);
        chk("rst_discard_valid", 32'(out_valid), 32'd0);
        in_valid = 1'b0;
        rst = 1'b0;

        // First edge after release captures normally
        issue(2'd0, 4'd6, 4'd7, 5'd13, 1'b0, 1'b0);
        idle(2);

        for (int i = 0; i < 5 && sb.size() > 0; i++) idle(1);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
